// File: rtl/rv_core_pkg.sv
// Shared core definitions: register-file geometry and index/word types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_core_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

  // Shared with decode and hazard units so register indices and words agree everywhere.
  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   word_t;

endpackage

// File: rtl/rf_word_reg.sv
// One N-bit architectural register with load enable and async active-low clear.
// Latency: d visible on q one clock after ld; clear is immediate.
// Backpressure: none; a load is always accepted.
module rf_word_reg
  import rv_core_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] data_d;
  logic [N-1:0] data_q;

  // Hold the stored word unless this register is the selected write target.
  always_comb begin
    data_d = data_q;
    if (ld) begin
      data_d = d;
    end
  end

  // Storage flop; reset clears without waiting for the clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Integer register file, 2 combinational read ports + 1 write port; x0 hardwired to 0. Optional macro: RF_WRITE_BYPASS_EN (WB->ID write-through forwarding).
// Latency: reads 0 cycles from address; writes visible the cycle after the edge (same cycle with bypass); wr_ack 1 cycle after the write.
// Backpressure: none; every write and read is accepted each cycle.
module reg_file_2r1w
  import rv_core_pkg::*;
#(
  parameter int N     = XLEN,
  parameter int NREGS = NUM_REGS,
  parameter int AW    = REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [N-1:0]  rd_data1,
  output logic [N-1:0]  rd_data2,
  output logic          wr_ack
);

  logic [N-1:0]       regs [NREGS];
  logic [NREGS-1:1]   wr_sel;
  logic               wr_live;
  logic               wr_ack_d;
  logic               wr_ack_q;

  // A write only changes state when enabled and not aimed at x0.
  assign wr_live = wr_en && (wr_addr != AW'(REG_X0));

  // One-hot write decoder gated by wr_en; x0 has no select line at all.
  always_comb begin
    wr_sel = '0;
    for (int j = 1; j < NREGS; j++) begin
      wr_sel[j] = wr_en && (wr_addr == AW'(j));
    end
  end

  // x0 has no storage.
  assign regs[0] = '0;

  genvar gi;
  for (gi = 1; gi < NREGS; gi++) begin : g_reg
    rf_word_reg #(.N(N)) u_reg (
      .clk (clk),
      .rst (rst),
      .ld  (wr_sel[gi]),
      .d   (wr_data),
      .q   (regs[gi])
    );
  end

  // NREGS:1 read muxes; the x0 rule overrides everything, including forwarding.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd_addr1 != AW'(REG_X0)) begin
      rd_data1 = regs[rd_addr1];
    end
    if (rd_addr2 != AW'(REG_X0)) begin
      rd_data2 = regs[rd_addr2];
    end
`ifdef RF_WRITE_BYPASS_EN
    // Forward the WB value to ID in the write cycle; suppressed while reset holds the file at 0.
    if (rst && wr_live && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_data;
    end
    if (rst && wr_live && (rd_addr2 == wr_addr)) begin
      rd_data2 = wr_data;
    end
`endif
  end

  // wr_ack pulses for exactly the cycle after a state-changing write.
  always_comb begin
    wr_ack_d = wr_live;
  end

  // Acknowledge flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_ack_d;
    end
  end

  assign wr_ack = wr_ack_q;

endmodule
